truth_table_sweeper: RTL and testbench

- Hardware counterpart of the exhaustive-stimulus bench used for the combinational exercises.
- On `start`, drives every input combination of an NUM_IN-input combinational function in binary order, with A as MSB, exactly as the bench sequence does.
- After a settle delay, samples the function output `f_in` for each combination and builds the captured truth table.
- Compares the captured table against an expected table and reports pass/fail, mismatch count and first failing index. Sits beside the DUT as its stimulus-and-response end.

---
 rtl/truth_table_sweeper_pkg.sv | 19 +
 rtl/truth_table_sweeper_if.sv | 31 +++
 rtl/truth_table_sweeper_settle_counter.sv | 30 +++
 rtl/truth_table_sweeper.sv | 117 +++++++++++
 tb/tb_truth_table_sweeper.sv | 206 ++++++++++++++++++++
 5 files changed

// File: rtl/truth_table_sweeper_pkg.sv
// Shared types for the truth-table sweeper: FSM states, settle counter width, table width helper.
// No logic; no latency; no flow control.
// Backpressure: not applicable.
package sweeper_pkg;

    typedef enum logic [1:0] {
        IDLE,
        DRIVE,
        SAMPLE,
        DONE
    } state_t;

    localparam int SETTLE_CNT_W = 4;

    function automatic int tw_of(input int num_in);
        return 1 << num_in;
    endfunction

endpackage

// File: rtl/truth_table_sweeper_if.sv
// Stimulus/response bundle between the sweeper and the combinational function under test.
// Pure wiring; zero latency.
// Backpressure: none, start/abort are level-sampled pulses.
interface truth_table_sweeper_if #(
    parameter int NUM_IN = 4
);
    localparam int TW = 1 << NUM_IN;

    logic              start;
    logic              abort;
    logic [TW-1:0]     exp_table;
    logic              f_in;
    logic [NUM_IN-1:0] vec;
    logic              busy;
    logic              done;
    logic              pass;
    logic [TW-1:0]     captured;
    logic [NUM_IN:0]   mismatch_cnt;
    logic [NUM_IN-1:0] first_fail_idx;

    modport master (
        input  start, abort, exp_table, f_in,
        output vec, busy, done, pass, captured, mismatch_cnt, first_fail_idx
    );

    modport slave (
        output start, abort, exp_table, f_in,
        input  vec, busy, done, pass, captured, mismatch_cnt, first_fail_idx
    );

endinterface

// File: rtl/truth_table_sweeper_settle_counter.sv
// Counts hold cycles for one applied vector and flags the last one before sampling.
// Flag is combinational from the registered count (SETTLE_CYCLES cycles after clear).
// Backpressure: none; en simply freezes the count.
module settle_counter
    import sweeper_pkg::*;
#(
    parameter int SETTLE_CYCLES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic en,
    output logic tc
);

    logic [SETTLE_CNT_W-1:0] cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (clear) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= cnt + SETTLE_CNT_W'(1);
        end
    end

    assign tc = (cnt == SETTLE_CNT_W'(SETTLE_CYCLES - 1));

endmodule

// File: rtl/truth_table_sweeper.sv
// Exhaustively drives every input vector, captures the function output and scores it against exp_table.
// Latency: done pulses TW*(SETTLE_CYCLES+1)+1 cycles after the accepted start edge.
// Backpressure: start ignored unless IDLE; abort cancels any sweep without done.
module truth_table_sweeper
    import sweeper_pkg::*;
#(
    parameter int NUM_IN        = 4,
    parameter int SETTLE_CYCLES = 2
) (
    input  logic                     clk,
    input  logic                     rst_n,
    truth_table_sweeper_if.master    bus
);

    localparam int             TW       = tw_of(NUM_IN);
    localparam int             IW       = NUM_IN + 1;
    localparam logic [IW-1:0]  LAST_IDX = IW'(TW - 1);

    state_t            state;
    logic [IW-1:0]     idx;
    logic [TW-1:0]     exp_q;
    logic [TW-1:0]     captured_q;
    logic [NUM_IN-1:0] vec_q;
    logic [NUM_IN-1:0] ffi_q;
    logic [NUM_IN:0]   mcnt_q;
    logic              busy_q;
    logic              done_q;
    logic              pass_q;
    logic              settle_tc;
    logic [NUM_IN-1:0] cur;

    assign cur = idx[NUM_IN-1:0];

    settle_counter #(
        .SETTLE_CYCLES(SETTLE_CYCLES)
    ) u_settle (
        .clk  (clk),
        .rst_n(rst_n),
        .clear(state != DRIVE),
        .en   (state == DRIVE),
        .tc   (settle_tc)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            idx        <= '0;
            exp_q      <= '0;
            captured_q <= '0;
            vec_q      <= '0;
            ffi_q      <= '0;
            mcnt_q     <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            pass_q     <= 1'b0;
        end else begin
            done_q <= 1'b0;
            // abort outranks everything, including a same-cycle sample update
            if (bus.abort && state != IDLE) begin
                state  <= IDLE;
                busy_q <= 1'b0;
                pass_q <= 1'b0;
            end else begin
                case (state)
                    IDLE: begin
                        if (bus.start && !bus.abort) begin
                            exp_q      <= bus.exp_table;
                            captured_q <= '0;
                            mcnt_q     <= '0;
                            ffi_q      <= '0;
                            pass_q     <= 1'b0;
                            idx        <= '0;
                            vec_q      <= '0;
                            busy_q     <= 1'b1;
                            state      <= DRIVE;
                        end
                    end
                    DRIVE: begin
                        vec_q <= cur;
                        if (settle_tc) state <= SAMPLE;
                    end
                    SAMPLE: begin
                        captured_q[cur] <= bus.f_in;
                        if (bus.f_in != exp_q[cur]) begin
                            mcnt_q <= mcnt_q + IW'(1);
                            if (mcnt_q == '0) ffi_q <= cur;
                        end
                        if (idx == LAST_IDX) begin
                            state <= DONE;
                        end else begin
                            // next vector goes out now so every vector gets the full hold time
                            idx   <= idx + IW'(1);
                            vec_q <= cur + NUM_IN'(1);
                            state <= DRIVE;
                        end
                    end
                    DONE: begin
                        done_q <= 1'b1;
                        busy_q <= 1'b0;
                        pass_q <= (mcnt_q == '0);
                        state  <= IDLE;
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

    assign bus.vec            = vec_q;
    assign bus.busy           = busy_q;
    assign bus.done           = done_q;
    assign bus.pass           = pass_q;
    assign bus.captured       = captured_q;
    assign bus.mismatch_cnt   = mcnt_q;
    assign bus.first_fail_idx = ffi_q;

endmodule

// File: tb/tb_truth_table_sweeper.sv
// Directed bench: behavioural function on vec, scoreboard of expected sweep results popped on done.
module tb_truth_table_sweeper;

    localparam int NUM_IN = 4;
    localparam int TW     = 16;
    localparam int SETTLE = 2;
    localparam int LAT    = TW * (SETTLE + 1) + 1;

    typedef struct {
        logic [15:0] cap;
        logic [4:0]  mcnt;
        logic [3:0]  ffi;
        logic        pass;
        int          t0;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_checks = 0;
    int   n_fail = 0;
    int   ecount = 0;
    int   mode = 0;
    exp_t sb[$];

    always #5 clk = ~clk;
    always @(posedge clk) ecount++;

    truth_table_sweeper_if #(.NUM_IN(NUM_IN)) bus ();

    truth_table_sweeper #(
        .NUM_IN(NUM_IN),
        .SETTLE_CYCLES(SETTLE)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    function automatic logic model_f(input int m, input logic [3:0] v);
        case (m)
            0:       return &v;
            2:       return ^v;
            default: return 1'b0;
        endcase
    endfunction

    always_comb bus.f_in = model_f(mode, bus.vec);

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push_exp(input int t0, input int m, input logic [15:0] et);
        exp_t e;
        logic [15:0] diff;
        for (int v = 0; v < TW; v++) e.cap[v] = model_f(m, 4'(v));
        diff   = e.cap ^ et;
        e.mcnt = '0;
        e.ffi  = '0;
        for (int v = TW - 1; v >= 0; v--) begin
            if (diff[v]) begin
                e.mcnt = e.mcnt + 5'd1;
                e.ffi  = 4'(v);
            end
        end
        e.pass = (diff == 16'h0);
        e.t0   = t0;
        sb.push_back(e);
    endtask

    // Start pulse sampled on the next edge; after return we sit #1 past that edge (edge 0).
    task automatic go(input bit track, input int m, input logic [15:0] et);
        mode          = m;
        bus.exp_table = et;
        bus.start     = 1'b1;
        step();
        bus.start     = 1'b0;
        if (track) push_exp(ecount, m, et);
    endtask

    always @(negedge clk) begin
        if (rst_n && bus.done === 1'b1) begin
            if (sb.size() == 0) begin
                check("unexpected_done", 32'd1, 32'd0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("done_latency", 32'(ecount - e.t0), 32'(LAT));
                check("captured",     32'(bus.captured), 32'(e.cap));
                check("mismatch_cnt", 32'(bus.mismatch_cnt), 32'(e.mcnt));
                check("first_fail",   32'(bus.first_fail_idx), 32'(e.ffi));
                check("pass",         32'(bus.pass), 32'(e.pass));
                check("busy_at_done", 32'(bus.busy), 32'd0);
            end
        end
    end

    initial begin
        bus.start     = 1'b0;
        bus.abort     = 1'b0;
        bus.exp_table = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_vec",      32'(bus.vec), 32'd0);
        check("rst_busy",     32'(bus.busy), 32'd0);
        check("rst_done",     32'(bus.done), 32'd0);
        check("rst_pass",     32'(bus.pass), 32'd0);
        check("rst_captured", 32'(bus.captured), 32'd0);
        check("rst_mcnt",     32'(bus.mismatch_cnt), 32'd0);
        check("rst_ffi",      32'(bus.first_fail_idx), 32'd0);
        rst_n = 1'b1;
        step();

        // AND4 against a matching table, with the vector sequence checked every cycle
        go(1'b1, 0, 16'h8000);
        for (int e = 0; e <= 48; e++) begin
            check("vec_step", 32'(bus.vec), (e < 48) ? 32'(e / 3) : 32'd15);
            if (e == 1) check("busy_sweep", 32'(bus.busy), 32'd1);
            step();
        end
        repeat (3) step();
        check("vec_hold_idle", 32'(bus.vec), 32'd15);
        check("pass_hold",     32'(bus.pass), 32'd1);

        // constant 0 against a two-entry table
        go(1'b1, 1, 16'h8001);
        repeat (55) step();

        // exp_table changed mid-sweep must not matter
        go(1'b1, 2, 16'h6996);
        repeat (10) step();
        bus.exp_table = 16'hFFFF;
        repeat (45) step();

        // stray starts mid-sweep ignored; start right after done accepted
        go(1'b1, 0, 16'h8000);
        for (int e = 1; e <= 110; e++) begin
            step();
            if (e == 4 || e == 19) bus.start = 1'b1;
            if (e == 5 || e == 20) bus.start = 1'b0;
            if (e == 49) begin
                check("done_at_49", 32'(bus.done), 32'd1);
                bus.start = 1'b1;
            end
            if (e == 50) begin
                bus.start = 1'b0;
                push_exp(ecount, 0, 16'h8000);
            end
            if (e == 99) check("done_at_99", 32'(bus.done), 32'd1);
        end

        // abort mid-sweep: partial results stay, no done
        go(1'b0, 2, 16'h6996);
        repeat (19) step();
        bus.abort = 1'b1;
        step();
        bus.abort = 1'b0;
        check("abort_busy",     32'(bus.busy), 32'd0);
        check("abort_pass",     32'(bus.pass), 32'd0);
        check("abort_captured", 32'(bus.captured), 32'h0016);
        check("abort_mcnt",     32'(bus.mismatch_cnt), 32'd0);
        repeat (60) step();
        go(1'b1, 2, 16'h6996);
        repeat (55) step();

        // abort and start together in IDLE: abort wins
        bus.abort = 1'b1;
        bus.start = 1'b1;
        step();
        bus.abort = 1'b0;
        bus.start = 1'b0;
        check("abort_start_idle", 32'(bus.busy), 32'd0);
        repeat (60) step();

        // asynchronous reset mid-sweep
        go(1'b0, 2, 16'h6996);
        repeat (29) step();
        check("busy_pre_rst", 32'(bus.busy), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_vec",      32'(bus.vec), 32'd0);
        check("arst_captured", 32'(bus.captured), 32'd0);
        check("arst_busy",     32'(bus.busy), 32'd0);
        check("arst_mcnt",     32'(bus.mismatch_cnt), 32'd0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (60) step();
        check("post_rst_busy", 32'(bus.busy), 32'd0);

        check("sb_drained", 32'(sb.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
